// File: rtl/xillybus_rd_stream_packer_if.sv
// Purpose : Bundles the sample-set handshake and the Xillybus read-stream
//           signals of xillybus_rd_stream_packer into one port.
// Signals : s_valid/s_ready/s_data  - sample set handshake (producer -> packer)
//           user_r_rden/user_r_open - Xillybus read enable / file open (core -> packer)
//           user_r_data/empty/eof   - Xillybus read data and status (packer -> core)
// Modports: master - producer/core side; slave - packer side.
interface xillybus_rd_stream_packer_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned WORD_W   = 32
);
  logic                       s_valid;
  logic                       s_ready;
  logic [NUM_CH*SAMPLE_W-1:0] s_data;
  logic                       user_r_rden;
  logic [WORD_W-1:0]          user_r_data;
  logic                       user_r_empty;
  logic                       user_r_eof;
  logic                       user_r_open;

  modport master (
    output s_valid, s_data, user_r_rden, user_r_open,
    input  s_ready, user_r_data, user_r_empty, user_r_eof
  );

  modport slave (
    input  s_valid, s_data, user_r_rden, user_r_open,
    output s_ready, user_r_data, user_r_empty, user_r_eof
  );
endinterface

// File: rtl/xillybus_rd_stream_packer.sv
// Purpose : Multi-channel capture front end for a Xillybus read stream.
//           Latches one NUM_CH-sample set per handshake, serialises it
//           channel 0 first, packs samples LSB-first into WORD_W words,
//           buffers them in a DEPTH-word non-FWFT FIFO and raises eof after
//           frame_len words have been read in the current open.
// Ports   : bus_clk, bus_rst  - clock, synchronous active-high reset
//           bus               - xillybus_rd_stream_packer_if.slave (handshake + user_r_*)
//           frame_len         - words per open before eof, 0 = unbounded
//           fill_level        - FIFO occupancy in words
//           drop_cnt          - discarded sample sets
// Config  : define PACK_DROP_CNT_EN to build the saturating drop counter;
//           otherwise drop_cnt is tied to 0.
module xillybus_rd_stream_packer #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned DEPTH    = 512
) (
  input  logic                     bus_clk,
  input  logic                     bus_rst,
  xillybus_rd_stream_packer_if.slave bus,
  input  logic [31:0]              frame_len,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [31:0]              drop_cnt
);

  localparam int unsigned P     = WORD_W / SAMPLE_W;
  localparam int unsigned IDX_W = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned SET_W = NUM_CH * SAMPLE_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [SET_W-1:0]    r_set;
  logic [CH_W-1:0]     r_ch;
  logic [IDX_W-1:0]    r_idx;
  logic [WORD_W-1:0]   r_pack;
  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic [CNT_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [31:0]         r_rd_words;
  logic                r_eof;
  logic                r_empty;
  logic                r_s_ready;
  logic [WORD_W-1:0]   r_data;

  logic                w_open;
  logic                w_live;
  logic                w_hs;
  logic                w_full;
  logic                w_word_due;
  logic                w_last_ch;
  logic                w_stall;
  logic                w_accept;
  logic                w_append;
  logic                w_fifo_wr;
  logic                w_rd;
  logic [SAMPLE_W-1:0] w_sample;
  logic [WORD_W-1:0]   w_word;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [31:0]         w_rd_words_nxt;
  logic                w_eof_nxt;

  // Status decode; "live" means sets are accepted into the packer
  assign w_open     = bus.user_r_open;
  assign w_live     = w_open & ~r_eof;
  assign w_hs       = bus.s_valid & r_s_ready;
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_word_due = (r_idx == IDX_W'(P - 1));
  assign w_last_ch  = (r_ch == CH_W'(NUM_CH - 1));
  // A completed word with nowhere to go freezes the packer
  assign w_stall    = w_word_due & w_full;
  assign w_rd       = bus.user_r_rden & ~r_empty & w_open;

  // Current sample and the pack register with it inserted at slot idx
  always_comb begin
    w_sample = r_set[int'(r_ch)*SAMPLE_W +: SAMPLE_W];
    w_word   = r_pack;
    w_word[int'(r_idx)*SAMPLE_W +: SAMPLE_W] = w_sample;
  end

  // FSM state register
  always_ff @(posedge bus_clk) begin
    if (bus_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state; closing the file or hitting eof abandons a set in progress
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_hs && w_live) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (!w_stall && w_last_ch) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (!w_live) w_state_nxt = ST_IDLE;
  end

  // FSM outputs: datapath strobes
  always_comb begin
    w_accept  = 1'b0;
    w_append  = 1'b0;
    w_fifo_wr = 1'b0;
    case (r_state)
      ST_IDLE:  w_accept = w_hs & w_live;
      ST_SHIFT: begin
        w_append  = w_live & ~w_stall;
        w_fifo_wr = w_live & ~w_stall & w_word_due;
      end
      default: ;
    endcase
  end

  assign w_count_nxt    = r_count + CNT_W'(w_fifo_wr) - CNT_W'(w_rd);
  assign w_rd_words_nxt = r_rd_words + 32'(w_rd);
  // eof is sticky for the rest of the open, whatever frame_len does later
  assign w_eof_nxt      = r_eof | ((frame_len != 32'd0) && (w_rd_words_nxt == frame_len));

  // FIFO storage (no reset; contents are qualified by the pointers)
  always_ff @(posedge bus_clk) begin
    if (w_fifo_wr) r_mem[r_wr_ptr[AW-1:0]] <= w_word;
  end

  // Packer, FIFO control, read port and eof tracking
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      r_set      <= '0;
      r_ch       <= '0;
      r_idx      <= '0;
      r_pack     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_words <= '0;
      r_eof      <= 1'b0;
      r_empty    <= 1'b1;
      r_s_ready  <= 1'b0;
      r_data     <= '0;
    end else begin
      r_s_ready <= (w_state_nxt == ST_IDLE);
      if (!w_open) begin
        // Closed: everything but the last read word is held cleared
        r_ch       <= '0;
        r_idx      <= '0;
        r_pack     <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_rd_words <= '0;
        r_eof      <= 1'b0;
        r_empty    <= 1'b1;
      end else begin
        if (w_accept) begin
          r_set <= bus.s_data;
          r_ch  <= '0;
        end
        if (w_append) begin
          r_pack <= w_word;
          r_idx  <= w_word_due ? '0 : r_idx + IDX_W'(1);
          r_ch   <= r_ch + CH_W'(1);
        end
        if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + CNT_W'(1);
        if (w_rd) begin
          r_data   <= r_mem[r_rd_ptr[AW-1:0]];
          r_rd_ptr <= r_rd_ptr + CNT_W'(1);
        end
        r_count    <= w_count_nxt;
        r_rd_words <= w_rd_words_nxt;
        r_eof      <= w_eof_nxt;
        r_empty    <= (w_count_nxt == '0) | w_eof_nxt;
      end
    end
  end

`ifdef PACK_DROP_CNT_EN
  logic        w_drop;
  logic [31:0] r_drop;

  // A set offered while closed or after eof is consumed and counted
  assign w_drop = w_hs & ~w_live;

  // Saturating drop counter, survives open/close
  always_ff @(posedge bus_clk) begin
    if (bus_rst)                          r_drop <= '0;
    else if (w_drop && (r_drop != '1))    r_drop <= r_drop + 32'd1;
  end

  assign drop_cnt = r_drop;
`else
  assign drop_cnt = '0;
`endif

  assign bus.s_ready      = r_s_ready;
  assign bus.user_r_data  = r_data;
  assign bus.user_r_empty = r_empty;
  assign bus.user_r_eof   = r_eof;
  assign fill_level       = r_count;

endmodule

// File: tb/tb_xillybus_rd_stream_packer.sv
// Purpose : Directed self-checking bench for xillybus_rd_stream_packer
//           (NUM_CH=2, SAMPLE_W=16, WORD_W=32, DEPTH=16).
module tb_xillybus_rd_stream_packer;

  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned DEPTH    = 16;
`ifdef PACK_DROP_CNT_EN
  localparam logic [31:0] DROP_EXP = 32'd9;
`else
  localparam logic [31:0] DROP_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] frame_len;
  logic [4:0]  fill_level;
  logic [31:0] drop_cnt;

  int n_chk = 0;
  int n_bad = 0;

  xillybus_rd_stream_packer_if #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .WORD_W(WORD_W)
  ) u_if ();

  xillybus_rd_stream_packer #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .WORD_W(WORD_W), .DEPTH(DEPTH)
  ) u_dut (
    .bus_clk    (clk),
    .bus_rst    (rst),
    .bus        (u_if),
    .frame_len  (frame_len),
    .fill_level (fill_level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer one set {b,a}; returns right after the handshake edge
  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    while (!u_if.s_ready && n < 100) begin
      tick();
      n++;
    end
    if (!u_if.s_ready) chk("push_ready_timeout", 64'(u_if.s_ready), 64'd1);
    u_if.s_valid = 1'b1;
    u_if.s_data  = {b, a};
    tick();
    u_if.s_valid = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    frame_len        = 32'd0;
    u_if.s_valid     = 1'b0;
    u_if.s_data      = '0;
    u_if.user_r_rden = 1'b0;
    u_if.user_r_open = 1'b0;
    ticks(2);
    chk("rst_s_ready", 64'(u_if.s_ready), 64'd0);
    chk("rst_empty",   64'(u_if.user_r_empty), 64'd1);
    chk("rst_eof",     64'(u_if.user_r_eof), 64'd0);
    chk("rst_data",    64'(u_if.user_r_data), 64'd0);
    chk("rst_fill",    64'(fill_level), 64'd0);
    chk("rst_drop",    64'(drop_cnt), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_s_ready", 64'(u_if.s_ready), 64'd1);

    // Basic packing, channel 0 in the low half
    u_if.user_r_open = 1'b1;
    tick();
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    ticks(3);
    chk("t1_fill", 64'(fill_level), 64'd2);
    chk("t1_empty", 64'(u_if.user_r_empty), 64'd0);
    u_if.user_r_rden = 1'b1;
    tick();
    chk("t1_word0", 64'(u_if.user_r_data), 64'h2222_1111);
    tick();
    chk("t1_word1", 64'(u_if.user_r_data), 64'h4444_3333);
    u_if.user_r_rden = 1'b0;
    chk("t1_fill_end", 64'(fill_level), 64'd0);
    chk("t1_empty_end", 64'(u_if.user_r_empty), 64'd1);

    // Reads while empty are ignored
    for (int i = 0; i < 3; i++) begin
      u_if.user_r_rden = 1'b1;
      tick();
      u_if.user_r_rden = 1'b0;
      tick();
    end
    chk("t4_data_hold", 64'(u_if.user_r_data), 64'h4444_3333);
    chk("t4_fill", 64'(fill_level), 64'd0);
    chk("t4_eof", 64'(u_if.user_r_eof), 64'd0);

    // Sets offered while closed are discarded
    u_if.user_r_open = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) push(16'hC000 | 16'(k), 16'hC100 | 16'(k));
    ticks(3);
    chk("closed_fill", 64'(fill_level), 64'd0);
    chk("closed_empty", 64'(u_if.user_r_empty), 64'd1);
    chk("closed_s_ready", 64'(u_if.s_ready), 64'd1);

    // frame_len = 3: eof after the third read, fourth word stays buffered
    frame_len        = 32'd3;
    u_if.user_r_open = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) push(16'hA000 | 16'(k), 16'hB000 | 16'(k));
    ticks(3);
    chk("t2_fill", 64'(fill_level), 64'd4);
    u_if.user_r_rden = 1'b1;
    tick();
    chk("t2_word1", 64'(u_if.user_r_data), 64'hB001_A001);
    chk("t2_no_eof_yet", 64'(u_if.user_r_eof), 64'd0);
    tick();
    chk("t2_word2", 64'(u_if.user_r_data), 64'hB002_A002);
    tick();
    chk("t2_word3", 64'(u_if.user_r_data), 64'hB003_A003);
    chk("t2_eof", 64'(u_if.user_r_eof), 64'd1);
    chk("t2_empty", 64'(u_if.user_r_empty), 64'd1);
    tick();
    u_if.user_r_rden = 1'b0;
    chk("t2_word4_blocked", 64'(u_if.user_r_data), 64'hB003_A003);
    chk("t2_fill_left", 64'(fill_level), 64'd1);
    push(16'hE001, 16'hE002);
    push(16'hE003, 16'hE004);
    ticks(3);
    chk("t2_post_eof_fill", 64'(fill_level), 64'd1);
    chk("t2_eof_hold", 64'(u_if.user_r_eof), 64'd1);
    frame_len = 32'd0;
    tick();
    chk("t2_eof_sticky", 64'(u_if.user_r_eof), 64'd1);
    u_if.user_r_open = 1'b0;
    tick();
    chk("t2_close_eof", 64'(u_if.user_r_eof), 64'd0);
    chk("t2_close_fill", 64'(fill_level), 64'd0);
    chk("t2_close_empty", 64'(u_if.user_r_empty), 64'd1);
    chk("drop_cnt", 64'(drop_cnt), 64'(DROP_EXP));

    // Fill to DEPTH, then stall and release with a single read
    u_if.user_r_open = 1'b1;
    tick();
    for (int k = 0; k < int'(DEPTH); k++) push(16'h5000 + 16'(k), 16'h6000 + 16'(k));
    ticks(3);
    chk("t3_full_fill", 64'(fill_level), 64'(DEPTH));
    push(16'h7000, 16'h7001);
    ticks(4);
    chk("t3_stall_s_ready", 64'(u_if.s_ready), 64'd0);
    chk("t3_stall_fill", 64'(fill_level), 64'(DEPTH));
    u_if.user_r_rden = 1'b1;
    tick();
    u_if.user_r_rden = 1'b0;
    chk("t3_read_data", 64'(u_if.user_r_data), 64'h6000_5000);
    chk("t3_read_fill", 64'(fill_level), 64'(DEPTH - 1));
    tick();
    chk("t3_refill", 64'(fill_level), 64'(DEPTH));
    chk("t3_release", 64'(u_if.s_ready), 64'd1);

    // Reset with 5 words buffered and a set half-shifted
    u_if.user_r_open = 1'b0;
    tick();
    u_if.user_r_open = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) push(16'h9000 + 16'(k), 16'h9100 + 16'(k));
    ticks(3);
    chk("t5_fill", 64'(fill_level), 64'd5);
    push(16'hDEAD, 16'hBEEF);
    tick();
    chk("t5_shift_active", 64'(u_if.s_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_empty", 64'(u_if.user_r_empty), 64'd1);
    chk("t5_fill_clr", 64'(fill_level), 64'd0);
    tick();
    chk("t5_s_ready", 64'(u_if.s_ready), 64'd1);
    chk("t5_drop_clr", 64'(drop_cnt), 64'd0);
    push(16'h7777, 16'h8888);
    ticks(3);
    chk("t5_fill_new", 64'(fill_level), 64'd1);
    u_if.user_r_rden = 1'b1;
    tick();
    u_if.user_r_rden = 1'b0;
    chk("t5_word_new", 64'(u_if.user_r_data), 64'h8888_7777);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
